fetch_unit: RTL and testbench

//  Parametrised, decoupled instruction-fetch stage for the pipelined CPU generation.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 80 ++++++++
 rtl/fetch_unit.sv | 80 ++++++++
 tb/tb_fetch_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-generation constants.
//   DEFAULT_ADDR_W    default PC / instruction-address width
//   DEFAULT_DATA_W    default instruction width
//   DEFAULT_RESET_PC  PC loaded on reset (truncated to the instance's ADDR_W)
//   PC_STEP           byte distance between consecutive instructions
package cpu_pkg;
  localparam int unsigned DEFAULT_ADDR_W   = 32;
  localparam int unsigned DEFAULT_DATA_W   = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned PC_STEP          = 4;
endpackage : cpu_pkg

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO holding fetched {instr, pc} pairs.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (pointers and count)
//   flush  synchronous flush; wins over push/pop in the same cycle
//   push   write wdata at the tail (accepted when not full, or when popping)
//   pop    consume the head entry (ignored when empty)
//   wdata  entry to write
//   rdata  head entry, valid whenever empty is low
//   full / empty / count  occupancy status
module fetch_fifo #(
  parameter  int unsigned WIDTH = 64,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the consumer gates the head with empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule : fetch_fifo

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage.
//   clk, reset               clock; asynchronous active-low reset
//   imem_req/addr/ready/rdata  instruction-memory port (ready = word returned)
//   redirect_valid/pc        new fetch target from EX; flushes buffered work
//   out_valid/ready          handshake towards decode
//   out_instr/pc/pc_plus_4   head instruction, its PC and link address
//   fifo_count               buffered entries
module fetch_unit
  import cpu_pkg::*;
#(
  parameter  int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter  int unsigned       DATA_W   = DEFAULT_DATA_W,
  parameter  int unsigned       DEPTH    = 4,
  parameter  logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC[ADDR_W-1:0],
  localparam int unsigned       CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus_4,
  output logic [CNT_W-1:0]  fifo_count
);

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic                     push, pop;
  logic                     fifo_full, fifo_empty;
  logic [DATA_W+ADDR_W-1:0] head;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  // Requesting while reset is low is suppressed so the port is idle in reset.
  assign imem_req  = reset & ~redirect_valid & (~fifo_full | pop);
  assign imem_addr = fetch_pc_q;
  assign push      = imem_req & imem_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (push)       fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  // Redirect flushes the buffer; any word returned that cycle is never pushed
  // because imem_req (and hence push) is already low.
  fetch_fifo #(
    .WIDTH (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata ({imem_rdata, fetch_pc_q}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Empty head reads as zero so reset/flush present clean outputs.
  assign out_instr     = out_valid ? head[DATA_W+ADDR_W-1:ADDR_W] : '0;
  assign out_pc        = out_valid ? head[ADDR_W-1:0] : '0;
  assign out_pc_plus_4 = out_pc + ADDR_W'(PC_STEP);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        reset, imem_req, imem_ready, redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, out_instr, out_pc, out_pc_plus_4;
  logic [2:0]  fifo_count;

  // Memory model: instruction word is the bitwise inverse of its address.
  assign imem_rdata = ~imem_addr;

  fetch_unit u_dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus_4  (out_pc_plus_4),
    .fifo_count     (fifo_count)
  );

  // 16-bit instance for PC wrap
  logic        r16, req16, out_valid16;
  logic [15:0] addr16, out_pc16, plus4_16;
  logic [31:0] rdata16, instr16;
  logic [2:0]  count16;
  assign rdata16 = {16'h0, ~addr16};

  fetch_unit #(.ADDR_W(16), .DATA_W(32), .DEPTH(4), .RESET_PC(16'hFFF8)) u_dut16 (
    .clk            (clk),
    .reset          (r16),
    .imem_req       (req16),
    .imem_addr      (addr16),
    .imem_ready     (1'b1),
    .imem_rdata     (rdata16),
    .redirect_valid (1'b0),
    .redirect_pc    (16'h0),
    .out_valid      (out_valid16),
    .out_ready      (1'b1),
    .out_instr      (instr16),
    .out_pc         (out_pc16),
    .out_pc_plus_4  (plus4_16),
    .fifo_count     (count16)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b0; r16 = 1'b0;
    imem_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();

    // Reset state
    chk("rst_req",   64'(imem_req),   64'd0);
    chk("rst_valid", 64'(out_valid),  64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_pc",    64'(out_pc),     64'd0);
    chk("rst_instr", 64'(out_instr),  64'd0);

    // 1: streaming, one instruction per cycle
    reset = 1'b1;
    #1;
    chk("t1_req0",  64'(imem_req),  64'd1);
    chk("t1_addr0", 64'(imem_addr), 64'h0);
    tick();
    chk("t1_valid", 64'(out_valid),     64'd1);
    chk("t1_pc0",   64'(out_pc),        64'h0);
    chk("t1_ins0",  64'(out_instr),     64'hFFFF_FFFF);
    chk("t1_p4_0",  64'(out_pc_plus_4), 64'h4);
    chk("t1_addr1", 64'(imem_addr),     64'h4);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("t1_pc%0d", k),  64'(out_pc),     64'(4 * k));
      chk($sformatf("t1_cnt%0d", k), 64'(fifo_count), 64'd1);
    end

    // 2: flush to 0, then fill with decode stalled
    redirect_valid = 1'b1; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    chk("t2_req_redir", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t2_cnt0", 64'(fifo_count), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t2_fill%0d", k), 64'(fifo_count), 64'(k));
    end
    chk("t2_req_full", 64'(imem_req),  64'd0);
    chk("t2_head",     64'(out_pc),    64'h0);
    chk("t2_addr",     64'(imem_addr), 64'h10);
    tick();
    chk("t2_hold_pc",  64'(out_pc),     64'h0);
    chk("t2_hold_cnt", 64'(fifo_count), 64'd4);

    // 3: full FIFO drains in order while refilling on the same edge
    out_ready = 1'b1;
    #1;
    chk("t3_req_full_pop", 64'(imem_req), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("t3_pc%0d", k),  64'(out_pc),     64'(4 * k));
      chk($sformatf("t3_cnt%0d", k), 64'(fifo_count), 64'd4);
    end

    // 4: redirect with three entries buffered
    imem_ready = 1'b0;
    tick();
    chk("t4_cnt3", 64'(fifo_count), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0100; imem_ready = 1'b1; out_ready = 1'b0;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_cnt",   64'(fifo_count), 64'd0);
    chk("t4_valid", 64'(out_valid),  64'd0);
    chk("t4_addr",  64'(imem_addr),  64'h0040_0100);
    chk("t4_req",   64'(imem_req),   64'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_pc",    64'(out_pc),    64'h0040_0100);
    chk("t4_instr", 64'(out_instr), 64'hFFBF_FEFF);
    tick();
    chk("t4_pc_n",  64'(out_pc),    64'h0040_0104);

    // 5: imem_ready pattern 1,0,0,1
    chk("t5_addr_a", 64'(imem_addr), 64'h0040_0108);
    tick();
    chk("t5_pc_a", 64'(out_pc), 64'h0040_0108);
    imem_ready = 1'b0;
    #1;
    chk("t5_addr_b", 64'(imem_addr), 64'h0040_010C);
    tick();
    chk("t5_valid_b", 64'(out_valid), 64'd0);
    chk("t5_addr_c",  64'(imem_addr), 64'h0040_010C);
    tick();
    imem_ready = 1'b1;
    #1;
    chk("t5_addr_d", 64'(imem_addr), 64'h0040_010C);
    tick();
    chk("t5_pc_d", 64'(out_pc), 64'h0040_010C);

    // Back-to-back redirects, last one wins; misaligned target passes through
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect_pc = 32'h0000_0302;
    #1;
    chk("bb_req", 64'(imem_req), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("bb_addr", 64'(imem_addr), 64'h0000_0302);
    tick();
    chk("bb_pc",   64'(out_pc),    64'h0000_0302);

    // 6: asynchronous reset between edges
    tick();
    reset = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid),  64'd0);
    chk("t6_cnt",   64'(fifo_count), 64'd0);
    chk("t6_req",   64'(imem_req),   64'd0);
    chk("t6_pc",    64'(out_pc),     64'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("t6_addr", 64'(imem_addr), 64'h0);
    tick();
    chk("t6_restart", 64'(out_pc), 64'h0);

    // 6b: 16-bit PC wrap 0xFFFC -> 0x0000
    r16 = 1'b1;
    #1;
    chk("w_addr0", 64'(addr16), 64'hFFF8);
    tick();
    chk("w_addr1", 64'(addr16),   64'hFFFC);
    chk("w_pc1",   64'(out_pc16), 64'hFFF8);
    tick();
    chk("w_addr2", 64'(addr16),   64'h0000);
    chk("w_pc2",   64'(out_pc16), 64'hFFFC);
    chk("w_p4_2",  64'(plus4_16), 64'h0000);
    chk("w_ins2",  64'(instr16),  64'h0000_0003);
    tick();
    chk("w_pc3",   64'(out_pc16), 64'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_fetch_unit
